// File: rtl/rx_frame_fifo_ctrl_if.sv
// Handshake and fifo-pointer bundle between the receive controller (master) and the MAC/fifo/host side (slave).
// Pure wiring with no latency. Backpressure comes only from the fifo-full and descriptor-full rollback inside the controller.
interface rx_frame_fifo_ctrl_if #(
    parameter int FIFO_DEPTH = 12
);
    logic                  rx_valid;
    logic                  rx_sof;
    logic                  rx_eof;
    logic                  rx_error;
    logic                  fifo_write_enable;
    logic [FIFO_DEPTH-1:0] fifo_write_address;
    logic                  fifo_write_rewind;
    logic [FIFO_DEPTH-1:0] fifo_write_rewind_address;
    logic                  fifo_read_enable;
    logic [FIFO_DEPTH-1:0] fifo_read_address;
    logic                  frame_available;
    logic [FIFO_DEPTH-1:0] frame_length;
    logic                  frame_read_request;
    logic                  frame_read_valid;
    logic                  frame_read_last;

    modport master (
        input  rx_valid, rx_sof, rx_eof, rx_error,
        input  fifo_write_address, fifo_read_address, frame_read_request,
        output fifo_write_enable, fifo_write_rewind, fifo_write_rewind_address,
        output fifo_read_enable, frame_available, frame_length,
        output frame_read_valid, frame_read_last
    );

    modport slave (
        output rx_valid, rx_sof, rx_eof, rx_error,
        output fifo_write_address, fifo_read_address, frame_read_request,
        input  fifo_write_enable, fifo_write_rewind, fifo_write_rewind_address,
        input  fifo_read_enable, frame_available, frame_length,
        input  frame_read_valid, frame_read_last
    );
endinterface

// File: rtl/rx_frame_fifo_ctrl.sv
// Frame-level write/read controller for a byte-wide MAC receive fifo; optional counters via RX_FRAME_FIFO_CTRL_STATS_EN.
// Latency: descriptor visible 1 cycle after eof; read enables start 1 cycle after request, valid lags enable by 1.
// Backpressure: none on rx; frames that hit fifo-full or descriptor-full are rewound and dropped.
module rx_frame_fifo_ctrl #(
    parameter int FIFO_DEPTH = 12,
    parameter int DESC_DEPTH = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    rx_frame_fifo_ctrl_if.master bus
`ifdef RX_FRAME_FIFO_CTRL_STATS_EN
    ,
    output logic [15:0]          good_frame_count,
    output logic [15:0]          dropped_frame_count
`endif
);
    localparam int DESC_ENTRIES = 1 << DESC_DEPTH;

    typedef logic [FIFO_DEPTH-1:0] addr_t;
    typedef enum logic [1:0] {W_IDLE, W_FRAME, W_REWIND, W_DROP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_STREAM, R_RELEASE} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    addr_t start_address;
    addr_t frame_len;
    addr_t release_address;
    addr_t read_remaining;
    logic  drop_after_rewind;
    logic  rd_en_q;
    logic  rd_valid_q;
    logic  rd_last_q;

    addr_t                 desc_mem [DESC_ENTRIES];
    logic [DESC_DEPTH-1:0] desc_wr_ptr;
    logic [DESC_DEPTH-1:0] desc_rd_ptr;
    logic [DESC_DEPTH:0]   desc_count;

    logic  wr_full;
    logic  too_long;
    logic  q_full;
    logic  q_empty;
    logic  wr_en;
    logic  push;
    logic  pop;
    addr_t push_len;

    assign wr_full  = (bus.fifo_write_address + addr_t'(1)) == release_address;
    // A frame may never occupy 2**FIFO_DEPTH-1 bytes, so refuse the byte that would reach that length.
    assign too_long = frame_len == {{(FIFO_DEPTH-1){1'b1}}, 1'b0};
    assign q_full   = desc_count[DESC_DEPTH];
    assign q_empty  = desc_count == '0;
    assign pop      = (r_state == R_IDLE) && bus.frame_read_request && !q_empty;

    always_comb begin
        wr_en    = 1'b0;
        push     = 1'b0;
        push_len = frame_len + addr_t'(1);
        case (w_state)
            W_IDLE: begin
                wr_en    = bus.rx_valid && bus.rx_sof && !wr_full;
                push     = wr_en && bus.rx_eof && !bus.rx_error && !q_full;
                push_len = addr_t'(1);
            end
            W_FRAME: begin
                wr_en = bus.rx_valid && !bus.rx_sof && !wr_full && !too_long;
                push  = wr_en && bus.rx_eof && !bus.rx_error && !q_full;
            end
            default: ;
        endcase
    end

    assign bus.fifo_write_enable         = wr_en && !reset;
    assign bus.fifo_write_rewind         = (w_state == W_REWIND);
    assign bus.fifo_write_rewind_address = start_address;

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state           <= W_IDLE;
            start_address     <= '0;
            frame_len         <= '0;
            drop_after_rewind <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (bus.rx_valid && bus.rx_sof) begin
                        start_address <= bus.fifo_write_address;
                        frame_len     <= addr_t'(1);
                        if (!wr_en) begin
                            w_state           <= W_REWIND;
                            drop_after_rewind <= !bus.rx_eof;
                        end else if (bus.rx_eof) begin
                            w_state           <= push ? W_IDLE : W_REWIND;
                            drop_after_rewind <= 1'b0;
                        end else begin
                            w_state <= W_FRAME;
                        end
                    end
                end
                W_FRAME: begin
                    if (bus.rx_valid) begin
                        if (!wr_en) begin
                            w_state           <= W_REWIND;
                            drop_after_rewind <= !bus.rx_eof;
                        end else begin
                            frame_len <= frame_len + addr_t'(1);
                            if (bus.rx_eof) begin
                                w_state           <= push ? W_IDLE : W_REWIND;
                                drop_after_rewind <= 1'b0;
                            end
                        end
                    end
                end
                // An eof seen while rewinding closes the abandoned frame, so there is nothing left to drop.
                W_REWIND: begin
                    if (bus.rx_valid && bus.rx_eof)
                        w_state <= W_IDLE;
                    else if ((bus.rx_valid && bus.rx_sof) || drop_after_rewind)
                        w_state <= W_DROP;
                    else
                        w_state <= W_IDLE;
                end
                W_DROP: begin
                    if (bus.rx_valid && bus.rx_eof)
                        w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            desc_mem[desc_wr_ptr] <= push_len;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            desc_wr_ptr <= '0;
            desc_rd_ptr <= '0;
            desc_count  <= '0;
        end else begin
            if (push)
                desc_wr_ptr <= desc_wr_ptr + 1'b1;
            if (pop)
                desc_rd_ptr <= desc_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   desc_count <= desc_count + 1'b1;
                2'b01:   desc_count <= desc_count - 1'b1;
                default: desc_count <= desc_count;
            endcase
        end
    end

    assign bus.frame_available = !q_empty;
    assign bus.frame_length    = q_empty ? '0 : desc_mem[desc_rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= R_IDLE;
            read_remaining  <= '0;
            release_address <= '0;
            rd_en_q         <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_last_q       <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_q;
            rd_last_q  <= (r_state == R_STREAM) && (read_remaining == addr_t'(1));
            case (r_state)
                R_IDLE: begin
                    if (pop) begin
                        read_remaining <= bus.frame_length;
                        rd_en_q        <= 1'b1;
                        r_state        <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    read_remaining <= read_remaining - addr_t'(1);
                    if (read_remaining == addr_t'(1)) begin
                        rd_en_q <= 1'b0;
                        r_state <= R_RELEASE;
                    end
                end
                // The fifo read pointer now sits one past the frame just streamed.
                R_RELEASE: begin
                    release_address <= bus.fifo_read_address;
                    r_state         <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign bus.fifo_read_enable = rd_en_q;
    assign bus.frame_read_valid = rd_valid_q;
    assign bus.frame_read_last  = rd_last_q;

`ifdef RX_FRAME_FIFO_CTRL_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            good_frame_count    <= '0;
            dropped_frame_count <= '0;
        end else begin
            if (push && good_frame_count != 16'hFFFF)
                good_frame_count <= good_frame_count + 16'd1;
            if (w_state == W_REWIND && dropped_frame_count != 16'hFFFF)
                dropped_frame_count <= dropped_frame_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rx_frame_fifo_ctrl.sv
// Directed bench for rx_frame_fifo_ctrl with a pointer-only fifo model (FIFO_DEPTH=7, DESC_DEPTH=3).
module tb_rx_frame_fifo_ctrl;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rx_frame_fifo_ctrl_if #(.FIFO_DEPTH(7)) bus ();

`ifdef RX_FRAME_FIFO_CTRL_STATS_EN
    logic [15:0] good_frame_count;
    logic [15:0] dropped_frame_count;
`endif

    rx_frame_fifo_ctrl #(.FIFO_DEPTH(7), .DESC_DEPTH(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef RX_FRAME_FIFO_CTRL_STATS_EN
        ,
        .good_frame_count    (good_frame_count),
        .dropped_frame_count (dropped_frame_count)
`endif
    );

    // Fifo pointer model: write pointer advances on enable or jumps on rewind, read pointer advances on enable.
    always @(posedge clock) begin
        if (reset) begin
            bus.fifo_write_address <= '0;
            bus.fifo_read_address  <= '0;
        end else begin
            if (bus.fifo_write_rewind)
                bus.fifo_write_address <= bus.fifo_write_rewind_address;
            else if (bus.fifo_write_enable)
                bus.fifo_write_address <= bus.fifo_write_address + 7'd1;
            if (bus.fifo_read_enable)
                bus.fifo_read_address <= bus.fifo_read_address + 7'd1;
        end
    end

    int checks = 0;
    int errors = 0;
    int we_cnt, rew_seen, rew_addr, rew_idx, avail_eof, avail_after;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives an n-byte frame (extra sof at sof_idx if >0), then two idle cycles, recording write/rewind activity.
    task automatic send_frame(input int n, input bit err, input int sof_idx);
        we_cnt = 0; rew_seen = 0; rew_addr = -1; rew_idx = -1; avail_eof = -1; avail_after = -1;
        for (int i = 0; i < n + 2; i++) begin
            step();
            bus.rx_valid = (i < n);
            bus.rx_sof   = (i == 0) || (i == sof_idx);
            bus.rx_eof   = (i == n - 1);
            bus.rx_error = err && (i == n - 1);
            if (i >= n) begin
                bus.rx_sof = 1'b0;
                bus.rx_eof = 1'b0;
            end
            #2;
            if (bus.fifo_write_enable) we_cnt++;
            if (bus.fifo_write_rewind && rew_seen == 0) begin
                rew_seen = 1;
                rew_addr = int'(bus.fifo_write_rewind_address);
                rew_idx  = i;
            end
            if (i == n - 1) avail_eof = int'(bus.frame_available);
            if (i == n) avail_after = int'(bus.frame_available);
        end
    endtask

    // Requests the head frame and checks the enable/valid/last shape of the stream.
    task automatic read_frame(input int len, input string tag, input bit avail_left);
        int re_cnt, v_cnt, last_cnt, first_re, first_v, last_k;
        re_cnt = 0; v_cnt = 0; last_cnt = 0; first_re = -1; first_v = -1; last_k = -1;
        step();
        bus.frame_read_request = 1'b1;
        #2;
        check({tag, "_len"}, bus.frame_length, len);
        for (int k = 0; k < len + 4; k++) begin
            step();
            bus.frame_read_request = (k == 1);
            #2;
            if (bus.fifo_read_enable) begin
                re_cnt++;
                if (first_re < 0) first_re = k;
            end
            if (bus.frame_read_valid) begin
                v_cnt++;
                if (first_v < 0) first_v = k;
            end
            if (bus.frame_read_last) begin
                last_cnt++;
                last_k = k;
            end
        end
        check({tag, "_enables"}, re_cnt, len);
        check({tag, "_valids"}, v_cnt, len);
        check({tag, "_valid_lag"}, first_v, first_re + 1);
        check({tag, "_last_count"}, last_cnt, 1);
        check({tag, "_last_pos"}, last_k, first_re + len);
        check({tag, "_avail_left"}, bus.frame_available, avail_left);
    endtask

    initial begin
        reset = 1'b1;
        bus.rx_valid = 0; bus.rx_sof = 0; bus.rx_eof = 0; bus.rx_error = 0;
        bus.frame_read_request = 0;
        repeat (3) step();
        #2;
        check("rst_wen", bus.fifo_write_enable, 0);
        check("rst_rewind", bus.fifo_write_rewind, 0);
        check("rst_rewind_addr", bus.fifo_write_rewind_address, 0);
        check("rst_ren", bus.fifo_read_enable, 0);
        check("rst_avail", bus.frame_available, 0);
        check("rst_len", bus.frame_length, 0);
        check("rst_rvalid", bus.frame_read_valid, 0);
        check("rst_rlast", bus.frame_read_last, 0);
        step();
        reset = 1'b0;

        // Good 64-byte frame, then stream it out.
        send_frame(64, 1'b0, -1);
        check("f1_writes", we_cnt, 64);
        check("f1_no_rewind", rew_seen, 0);
        check("f1_avail_at_eof", avail_eof, 0);
        check("f1_avail_after", avail_after, 1);
        check("f1_wr_addr", bus.fifo_write_address, 64);
        read_frame(64, "f1", 1'b0);
        check("f1_rd_addr", bus.fifo_read_address, 64);

        // 60-byte frame with an error: rewind to its start the cycle after eof.
        send_frame(60, 1'b1, -1);
        check("err_writes", we_cnt, 60);
        check("err_rewind_cycle", rew_idx, 60);
        check("err_rewind_addr", rew_addr, 64);
        check("err_avail", avail_after, 0);
        check("err_wr_addr", bus.fifo_write_address, 64);

        // 100 bytes wrap to 36; next 40-byte frame hits full at write address 63 (release = 64).
        send_frame(100, 1'b0, -1);
        check("a_writes", we_cnt, 100);
        check("a_wr_addr", bus.fifo_write_address, 36);
        send_frame(40, 1'b0, -1);
        check("ovf_writes", we_cnt, 27);
        check("ovf_rewind_cycle", rew_idx, 28);
        check("ovf_rewind_addr", rew_addr, 36);
        check("ovf_wr_addr", bus.fifo_write_address, 36);
        check("ovf_avail", bus.frame_available, 1);
        check("ovf_head_len", bus.frame_length, 100);
        read_frame(100, "fa", 1'b0);
        check("fa_rd_addr", bus.fifo_read_address, 36);

        // Nine 10-byte frames with an 8-entry queue: the ninth rolls back to 36+80.
        for (int f = 0; f < 8; f++) send_frame(10, 1'b0, -1);
        check("q8_no_rewind", rew_seen, 0);
        send_frame(10, 1'b0, -1);
        check("q9_rewind_cycle", rew_idx, 10);
        check("q9_rewind_addr", rew_addr, 116);
        check("q9_wr_addr", bus.fifo_write_address, 116);
        for (int f = 0; f < 8; f++) read_frame(10, "q", f < 7);
        check("q_rd_addr", bus.fifo_read_address, 116);

        // sof on the 5th byte: rewind to frame start, drop through eof, then a normal frame is accepted.
        send_frame(12, 1'b0, 4);
        check("sof_writes", we_cnt, 4);
        check("sof_rewind_cycle", rew_idx, 5);
        check("sof_rewind_addr", rew_addr, 116);
        check("sof_avail", avail_after, 0);
        send_frame(3, 1'b0, -1);
        check("post_sof_writes", we_cnt, 3);
        check("post_sof_avail", avail_after, 1);
        check("post_sof_len", bus.frame_length, 3);
        check("post_sof_wr_addr", bus.fifo_write_address, 119);

`ifdef RX_FRAME_FIFO_CTRL_STATS_EN
        check("stat_good", good_frame_count, 11);
        check("stat_dropped", dropped_frame_count, 4);
`endif

        // Reset while streaming the 3-byte frame.
        step();
        bus.frame_read_request = 1'b1;
        #2;
        step();
        bus.frame_read_request = 1'b0;
        #2;
        check("rs_stream_en", bus.fifo_read_enable, 1);
        step();
        reset = 1'b1;
        #2;
        step();
        #2;
        check("rs_ren", bus.fifo_read_enable, 0);
        check("rs_avail", bus.frame_available, 0);
        check("rs_rvalid", bus.frame_read_valid, 0);
        check("rs_rewind", bus.fifo_write_rewind, 0);
`ifdef RX_FRAME_FIFO_CTRL_STATS_EN
        check("rs_stat_good", good_frame_count, 0);
        check("rs_stat_dropped", dropped_frame_count, 0);
`endif
        step();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
